// File: rtl/ex_mem_result_stage_pkg.sv
// Shared definitions for the EX/MEM result stage: access sizes, occupancy
// states and the layout width of one captured instruction entry.
package ex_mem_result_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

    // reg_write, mem_read, mem_write, funct3[2:0], misaligned
    localparam int ENTRY_CTRL_W = 7;

    function automatic int entry_width(input int xlen, input int reg_addr_w);
        return 2 * xlen + reg_addr_w + ENTRY_CTRL_W;
    endfunction

    localparam int ENTRY_W = entry_width(32, 5);

    function automatic logic is_misaligned(input logic       mem_access,
                                           input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF) bad = addr_lo[0];
        else if (size == SZ_WORD) bad = (addr_lo != 2'b00);
        return mem_access & bad;
    endfunction

endpackage

// File: rtl/ex_mem_result_stage_if.sv
// Handshake bundle between EX, the EX/MEM result stage and the memory stage,
// including the forwarding tap back into EX.
interface ex_mem_result_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  FLUSH;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [XLEN-1:0]       ALU_OUTPUT;
    logic [REG_ADDR_W-1:0] RD_ADDR;
    logic                  REG_WRITE;
    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [XLEN-1:0]       STORE_DATA;
    logic [2:0]            FUNCT3;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [XLEN-1:0]       OUT_ALU_RESULT;
    logic [REG_ADDR_W-1:0] OUT_RD_ADDR;
    logic                  OUT_REG_WRITE;
    logic                  OUT_MEM_READ;
    logic                  OUT_MEM_WRITE;
    logic [XLEN-1:0]       OUT_STORE_DATA;
    logic [2:0]            OUT_FUNCT3;
    logic                  OUT_MISALIGNED;
    logic                  FWD_VALID;
    logic [REG_ADDR_W-1:0] FWD_RD_ADDR;
    logic [XLEN-1:0]       FWD_DATA;

    modport slave (
        input  FLUSH, IN_VALID, ALU_OUTPUT, RD_ADDR, REG_WRITE, MEM_READ,
               MEM_WRITE, STORE_DATA, FUNCT3, OUT_READY,
        output IN_READY, OUT_VALID, OUT_ALU_RESULT, OUT_RD_ADDR, OUT_REG_WRITE,
               OUT_MEM_READ, OUT_MEM_WRITE, OUT_STORE_DATA, OUT_FUNCT3,
               OUT_MISALIGNED, FWD_VALID, FWD_RD_ADDR, FWD_DATA
    );

    modport master (
        output FLUSH, IN_VALID, ALU_OUTPUT, RD_ADDR, REG_WRITE, MEM_READ,
               MEM_WRITE, STORE_DATA, FUNCT3, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_ALU_RESULT, OUT_RD_ADDR, OUT_REG_WRITE,
               OUT_MEM_READ, OUT_MEM_WRITE, OUT_STORE_DATA, OUT_FUNCT3,
               OUT_MISALIGNED, FWD_VALID, FWD_RD_ADDR, FWD_DATA
    );
endinterface

// File: rtl/ex_mem_entry_reg.sv
// One payload slot of the result stage: loads on enable, clears on reset,
// otherwise holds. Validity lives in the parent's occupancy state.
module ex_mem_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/ex_mem_result_stage.sv
// EX/MEM boundary register with a two-entry skid buffer so the memory stage
// can stall without a combinational ready path back into EX.
module ex_mem_result_stage
    import ex_mem_result_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                CLK,
    input  logic                RST_N,
    ex_mem_result_stage_if.slave bus
);

    localparam int EW      = entry_width(XLEN, REG_ADDR_W);
    localparam int OFF_MR  = 5;
    localparam int OFF_RW  = 6;
    localparam int OFF_RD  = 7;
    localparam int OFF_ALU = 7 + REG_ADDR_W + XLEN;

    occ_state_t      state;
    logic            in_ready_q;
    logic            main_valid, skid_valid, accept, drain;
    logic            load_new_main, load_skid, move_skid, main_load;
    logic            new_rw, new_mis;
    logic [EW-1:0]   new_entry, main_d, main_q, skid_q;
    logic            fwd_rw, fwd_mr, fwd_ok;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_alu;

    assign main_valid = (state != ST_EMPTY);
    assign skid_valid = (state == ST_FULL);
    assign accept     = bus.IN_VALID & in_ready_q;
    assign drain      = main_valid & bus.OUT_READY;

    // rd==0 never writes, so the forwarding tap can never match x0.
    assign new_rw    = bus.REG_WRITE & (bus.RD_ADDR != '0);
    assign new_mis   = is_misaligned(bus.MEM_READ | bus.MEM_WRITE, bus.FUNCT3[1:0],
                                     bus.ALU_OUTPUT[1:0]);
    assign new_entry = {bus.ALU_OUTPUT, bus.STORE_DATA, bus.RD_ADDR, new_rw,
                        bus.MEM_READ, bus.MEM_WRITE, bus.FUNCT3, new_mis};

    always_comb begin
        load_new_main = 1'b0;
        load_skid     = 1'b0;
        move_skid     = 1'b0;
        if (!bus.FLUSH) begin
            unique case (state)
                ST_EMPTY: load_new_main = accept;
                ST_ONE: begin
                    load_new_main = accept & drain;
                    load_skid     = accept & ~drain;
                end
                ST_FULL:  move_skid = drain;
                default: ;
            endcase
        end
    end

    assign main_load = load_new_main | move_skid;
    assign main_d    = move_skid ? skid_q : new_entry;

    ex_mem_entry_reg #(.W(EW)) u_main (
        .clk(CLK), .rst_n(RST_N), .load(main_load), .d(main_d), .q(main_q)
    );

    ex_mem_entry_reg #(.W(EW)) u_skid (
        .clk(CLK), .rst_n(RST_N), .load(load_skid), .d(new_entry), .q(skid_q)
    );

    // IN_READY comes straight from a flop so OUT_READY never reaches it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else if (bus.FLUSH) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: if (accept) state <= ST_ONE;
                ST_ONE: begin
                    if (accept && !drain) begin
                        state      <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (!accept && drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = main_valid;
    assign {bus.OUT_ALU_RESULT, bus.OUT_STORE_DATA, bus.OUT_RD_ADDR, bus.OUT_REG_WRITE,
            bus.OUT_MEM_READ, bus.OUT_MEM_WRITE, bus.OUT_FUNCT3, bus.OUT_MISALIGNED} = main_q;

    // The youngest entry feeds forwarding; loads are excluded since data is not back yet.
    assign fwd_rw  = skid_valid ? skid_q[OFF_RW] : main_q[OFF_RW];
    assign fwd_mr  = skid_valid ? skid_q[OFF_MR] : main_q[OFF_MR];
    assign fwd_rd  = skid_valid ? skid_q[OFF_RD +: REG_ADDR_W] : main_q[OFF_RD +: REG_ADDR_W];
    assign fwd_alu = skid_valid ? skid_q[OFF_ALU +: XLEN] : main_q[OFF_ALU +: XLEN];
    assign fwd_ok  = main_valid & fwd_rw & ~fwd_mr;

    assign bus.FWD_VALID   = fwd_ok;
    assign bus.FWD_RD_ADDR = fwd_ok ? fwd_rd : '0;
    assign bus.FWD_DATA    = fwd_ok ? fwd_alu : '0;

endmodule
